// File: rtl/fbm_pkg.sv
// Shared definitions for frame_buffer_manager: statistics counter width,
// the largest supported buffer count and the writer's free-buffer selection.
package fbm_pkg;

    localparam int STATS_W         = 16;
    localparam int MAX_NUM_BUFFERS = 16;

    // Next buffer for the writer after finishing a frame in buffer wr.
    // The following buffer is used unless the reader holds it; then the
    // writer skips one further. With at least three buffers the result is
    // never wr and never rd.
    function automatic int unsigned next_free_idx(input int unsigned wr,
                                                  input int unsigned rd,
                                                  input int unsigned n);
        int unsigned n1;
        n1 = (wr + 1) % n;
        if (n1 == rd) begin
            n1 = (wr + 2) % n;
        end
        return n1;
    endfunction

endpackage

// File: rtl/frame_buffer_manager.sv
// Tear-free N-buffer frame store controller.
// Tracks the buffer being written, the buffer being scanned out and the
// newest complete frame. The writer never targets the reader's buffer; the
// reader picks up the newest complete frame at each of its frame starts.
// Optional feature macro: FRAME_BUFFER_MANAGER_STATS_EN enables the
// drop_count / repeat_count statistics; otherwise both ports read 0.
//
// Event semantics: wr_finish and rd_start are single-cycle events with no
// backpressure. Every high cycle is one event and is accepted in that
// cycle; all outputs reflect it on the following cycle.
module frame_buffer_manager
    import fbm_pkg::*;
#(
    parameter int NUM_BUFFERS = 3,
    parameter int BUFFER_SIZE = 1 << 23,
    parameter int ADDR_WIDTH  = 32,
    localparam int IDX_W      = $clog2(NUM_BUFFERS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] base_address,
    input  logic                  wr_finish,
    input  logic                  rd_start,
    output logic [ADDR_WIDTH-1:0] wr_address,
    output logic [ADDR_WIDTH-1:0] rd_address,
    output logic                  rd_valid,
    output logic [IDX_W-1:0]      wr_idx,
    output logic [IDX_W-1:0]      rd_idx,
    output logic [STATS_W-1:0]    drop_count,
    output logic [STATS_W-1:0]    repeat_count
);

    logic [IDX_W-1:0] latest_idx;
    logic             latest_new;

    logic [IDX_W-1:0] nxt_wr_idx;
    logic [IDX_W-1:0] nxt_rd_idx;
    logic [IDX_W-1:0] nxt_latest_idx;
    logic             nxt_latest_new;
    logic             nxt_rd_valid;

    // Start address of buffer idx; the multiply is by a constant.
    function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [ADDR_WIDTH-1:0] base,
                                                      input logic [IDX_W-1:0]      idx);
        return base + ADDR_WIDTH'(idx) * ADDR_WIDTH'(BUFFER_SIZE);
    endfunction

    // Next-state selection for the buffer indices and the latest-frame flag.
    always_comb begin
        nxt_wr_idx     = wr_idx;
        nxt_rd_idx     = rd_idx;
        nxt_latest_idx = latest_idx;
        nxt_latest_new = latest_new;
        nxt_rd_valid   = rd_valid;
        if (wr_finish && rd_start) begin
            // Reader takes the just-finished frame; the old reader buffer is
            // released, so the writer simply advances by one.
            nxt_rd_idx     = wr_idx;
            nxt_latest_idx = wr_idx;
            nxt_latest_new = 1'b0;
            nxt_rd_valid   = 1'b1;
            nxt_wr_idx     = IDX_W'((32'(wr_idx) + 32'd1) % 32'(NUM_BUFFERS));
        end else if (wr_finish) begin
            nxt_latest_idx = wr_idx;
            nxt_latest_new = 1'b1;
            nxt_wr_idx     = IDX_W'(next_free_idx(32'(wr_idx), 32'(rd_idx),
                                                  32'(NUM_BUFFERS)));
        end else if (rd_start) begin
            if (latest_new) begin
                nxt_rd_idx     = latest_idx;
                nxt_latest_new = 1'b0;
                nxt_rd_valid   = 1'b1;
            end
        end
    end

    // Index, flag and address registers; addresses are computed from the
    // next indices so they line up with the index outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_idx     <= '0;
            rd_idx     <= IDX_W'(NUM_BUFFERS - 1);
            latest_idx <= '0;
            latest_new <= 1'b0;
            rd_valid   <= 1'b0;
            wr_address <= base_address;
            rd_address <= addr_of(base_address, IDX_W'(NUM_BUFFERS - 1));
        end else begin
            wr_idx     <= nxt_wr_idx;
            rd_idx     <= nxt_rd_idx;
            latest_idx <= nxt_latest_idx;
            latest_new <= nxt_latest_new;
            rd_valid   <= nxt_rd_valid;
            wr_address <= addr_of(base_address, nxt_wr_idx);
            rd_address <= addr_of(base_address, nxt_rd_idx);
        end
    end

`ifdef FRAME_BUFFER_MANAGER_STATS_EN
    logic               drop_inc;
    logic               repeat_inc;
    logic [STATS_W-1:0] drop_q;
    logic [STATS_W-1:0] repeat_q;

    // A finished frame is dropped when the previous one was never shown;
    // a reader start without a new frame repeats the current one.
    assign drop_inc   = wr_finish & latest_new;
    assign repeat_inc = rd_start & ~wr_finish & ~latest_new;

    // Saturating statistics counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_q   <= '0;
            repeat_q <= '0;
        end else begin
            if (drop_inc && (drop_q != '1)) begin
                drop_q <= drop_q + 1'b1;
            end
            if (repeat_inc && (repeat_q != '1)) begin
                repeat_q <= repeat_q + 1'b1;
            end
        end
    end

    assign drop_count   = drop_q;
    assign repeat_count = repeat_q;
`else
    assign drop_count   = '0;
    assign repeat_count = '0;
`endif

endmodule

// File: tb/tb_frame_buffer_manager.sv
// Self-checking bench for frame_buffer_manager (N=3, 8 MiB stride).
// A reference model computes the expected outputs as each cycle is driven;
// they are queued and compared one cycle later when the DUT reflects them.
module tb_frame_buffer_manager;
    import fbm_pkg::*;

    localparam int          N    = 3;
    localparam int          SIZE = 32'h0080_0000;
    localparam logic [31:0] BASE = 32'h1000_0000;
`ifdef FRAME_BUFFER_MANAGER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] wr_address;
        logic [31:0] rd_address;
        logic        rd_valid;
        logic [1:0]  wr_idx;
        logic [1:0]  rd_idx;
        logic [15:0] drop_count;
        logic [15:0] repeat_count;
    } exp_t;
    localparam int EXP_W = $bits(exp_t);

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] base_address;
    logic        wr_finish;
    logic        rd_start;
    logic [31:0] wr_address;
    logic [31:0] rd_address;
    logic        rd_valid;
    logic [1:0]  wr_idx;
    logic [1:0]  rd_idx;
    logic [15:0] drop_count;
    logic [15:0] repeat_count;

    logic [EXP_W-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    // Model state
    int unsigned m_wr, m_rd, m_latest, m_drop, m_rep;
    bit          m_new, m_valid;

    frame_buffer_manager #(
        .NUM_BUFFERS(N),
        .BUFFER_SIZE(SIZE),
        .ADDR_WIDTH (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .base_address(base_address),
        .wr_finish   (wr_finish),
        .rd_start    (rd_start),
        .wr_address  (wr_address),
        .rd_address  (rd_address),
        .rd_valid    (rd_valid),
        .wr_idx      (wr_idx),
        .rd_idx      (rd_idx),
        .drop_count  (drop_count),
        .repeat_count(repeat_count)
    );

    // Clock
    always #5 clk = ~clk;

    // Drive one cycle: update model, queue expected outputs, advance past the edge.
    task automatic step(input logic wf, input logic rs, input logic rst);
        exp_t e;
        reset     = rst;
        wr_finish = wf;
        rd_start  = rs;
        if (rst) begin
            m_wr = 0; m_rd = N - 1; m_latest = 0; m_new = 0; m_valid = 0;
            m_drop = 0; m_rep = 0;
        end else if (wf && rs) begin
            if (m_new && m_drop < 16'hFFFF) m_drop++;
            m_rd = m_wr; m_latest = m_wr; m_new = 0; m_valid = 1;
            m_wr = (m_wr + 1) % N;
        end else if (wf) begin
            if (m_new && m_drop < 16'hFFFF) m_drop++;
            m_latest = m_wr; m_new = 1;
            m_wr = next_free_idx(m_wr, m_rd, N);
        end else if (rs) begin
            if (m_new) begin
                m_rd = m_latest; m_new = 0; m_valid = 1;
            end else if (m_rep < 16'hFFFF) begin
                m_rep++;
            end
        end
        e.wr_address   = BASE + m_wr * SIZE;
        e.rd_address   = BASE + m_rd * SIZE;
        e.rd_valid     = m_valid;
        e.wr_idx       = 2'(m_wr);
        e.rd_idx       = 2'(m_rd);
        e.drop_count   = STATS ? 16'(m_drop) : 16'h0;
        e.repeat_count = STATS ? 16'(m_rep) : 16'h0;
        exp_q.push_back(EXP_W'(e));
        @(posedge clk);
        #1;
    endtask

    task automatic pop_exp(output exp_t e);
        e = exp_t'(exp_q.pop_front());
    endtask

    task automatic test_reset;
        exp_t e;
        step(1'b0, 1'b0, 1'b1);
        pop_exp(e);
        total++;
        if (wr_address !== 32'h1000_0000) begin
            bad++; $display("FAIL reset_wr_address got=%h exp=%h", wr_address, 32'h1000_0000);
        end
        total++;
        if (rd_address !== 32'h1100_0000) begin
            bad++; $display("FAIL reset_rd_address got=%h exp=%h", rd_address, 32'h1100_0000);
        end
        total++;
        if ({rd_valid, drop_count, repeat_count} !== {e.rd_valid, e.drop_count, e.repeat_count}) begin
            bad++; $display("FAIL reset_flags got=%b/%h/%h exp=0/0/0", rd_valid, drop_count, repeat_count);
        end
    endtask

    task automatic test_write_then_read;
        exp_t e;
        step(1'b1, 1'b0, 1'b0);
        pop_exp(e);
        total++;
        if (wr_address !== 32'h1080_0000 || wr_address !== e.wr_address) begin
            bad++; $display("FAIL wr1_wr_address got=%h exp=%h", wr_address, 32'h1080_0000);
        end
        step(1'b0, 1'b1, 1'b0);
        pop_exp(e);
        total++;
        if (rd_address !== 32'h1000_0000) begin
            bad++; $display("FAIL rd1_rd_address got=%h exp=%h", rd_address, 32'h1000_0000);
        end
        total++;
        if (rd_valid !== 1'b1 || repeat_count !== 16'h0) begin
            bad++; $display("FAIL rd1_valid_repeat got=%b/%h exp=1/0", rd_valid, repeat_count);
        end
    endtask

    task automatic test_drop;
        exp_t e;
        step(1'b1, 1'b0, 1'b0);
        pop_exp(e);
        total++;
        if (wr_idx !== 2'd2 || wr_address !== e.wr_address || wr_address === 32'h1000_0000) begin
            bad++; $display("FAIL drop_first_wr got=%0d/%h exp=2/%h", wr_idx, wr_address, e.wr_address);
        end
        step(1'b1, 1'b0, 1'b0);
        pop_exp(e);
        total++;
        if (wr_idx !== 2'd1 || wr_address !== 32'h1080_0000) begin
            bad++; $display("FAIL drop_skip_wr got=%0d/%h exp=1/10800000", wr_idx, wr_address);
        end
        total++;
        if (drop_count !== (STATS ? 16'd1 : 16'd0) || drop_count !== e.drop_count) begin
            bad++; $display("FAIL drop_count got=%h exp=%h", drop_count, e.drop_count);
        end
    endtask

    task automatic test_simultaneous;
        exp_t e;
        step(1'b1, 1'b1, 1'b0);
        pop_exp(e);
        total++;
        if (rd_address !== 32'h1080_0000 || wr_address !== 32'h1100_0000) begin
            bad++; $display("FAIL both_addresses got=%h/%h exp=10800000/11000000", rd_address, wr_address);
        end
        total++;
        if ({rd_valid, wr_idx, rd_idx, drop_count} !== {e.rd_valid, e.wr_idx, e.rd_idx, e.drop_count}) begin
            bad++; $display("FAIL both_state got=%b/%0d/%0d/%h exp=%b/%0d/%0d/%h", rd_valid, wr_idx, rd_idx,
                            drop_count, e.rd_valid, e.wr_idx, e.rd_idx, e.drop_count);
        end
    endtask

    task automatic test_repeat_saturate;
        exp_t e;
        step(1'b0, 1'b1, 1'b0);
        pop_exp(e);
        total++;
        if (rd_address !== 32'h1080_0000 || repeat_count !== e.repeat_count) begin
            bad++; $display("FAIL repeat_one got=%h/%h exp=10800000/%h", rd_address, repeat_count, e.repeat_count);
        end
        for (int i = 0; i < 70000; i++) begin
            step(1'b0, 1'b1, 1'b0);
            pop_exp(e);
        end
        total++;
        if (repeat_count !== (STATS ? 16'hFFFF : 16'h0) || repeat_count !== e.repeat_count) begin
            bad++; $display("FAIL repeat_saturate got=%h exp=%h", repeat_count, e.repeat_count);
        end
    endtask

    task automatic test_reset_mid_stream;
        exp_t e;
        step(1'b1, 1'b0, 1'b0);
        pop_exp(e);
        step(1'b1, 1'b0, 1'b1);
        pop_exp(e);
        total++;
        if ({wr_address, rd_address, rd_valid, wr_idx, rd_idx, drop_count, repeat_count} !==
            {32'h1000_0000, 32'h1100_0000, 1'b0, 2'd0, 2'd2, 16'h0, 16'h0}) begin
            bad++; $display("FAIL reset_mid got=%h/%h/%b/%0d/%0d/%h/%h", wr_address, rd_address, rd_valid,
                            wr_idx, rd_idx, drop_count, repeat_count);
        end
    endtask

    task automatic test_random;
        exp_t e;
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 40) == 0));
            pop_exp(e);
            total++;
            if ({wr_address, rd_address, rd_valid, wr_idx, rd_idx, drop_count, repeat_count} !== EXP_W'(e)) begin
                bad++; $display("FAIL random_cycle%0d got=%h/%h/%b/%0d/%0d/%h/%h exp=%h/%h/%b/%0d/%0d/%h/%h", i,
                                wr_address, rd_address, rd_valid, wr_idx, rd_idx, drop_count, repeat_count,
                                e.wr_address, e.rd_address, e.rd_valid, e.wr_idx, e.rd_idx, e.drop_count,
                                e.repeat_count);
            end
            total++;
            if (wr_idx === rd_idx) begin
                bad++; $display("FAIL random_invariant cycle%0d wr_idx=%0d rd_idx=%0d must differ", i, wr_idx, rd_idx);
            end
        end
    endtask

    initial begin
        reset        = 1'b1;
        base_address = BASE;
        wr_finish    = 1'b0;
        rd_start     = 1'b0;
        test_reset();
        test_write_then_read();
        test_drop();
        test_simultaneous();
        test_repeat_saturate();
        test_reset_mid_stream();
        test_random();
        total++;
        if (exp_q.size() !== 0) begin
            bad++; $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frame_buffer_manager.md
# frame_buffer_manager

Tear-free N-buffer frame store controller between the DDR writer and DDR reader of the video pipeline. Tracks which buffer is being written, which is being displayed, and which holds the latest complete frame. The writer never overwrites the buffer the reader is scanning out. The reader always picks up the newest complete frame at its own frame start, repeating a frame when none is new and dropping stale frames when the writer runs faster.

## Interface
- NUM_BUFFERS, 3, number of frame buffers; legal range 3..16.
- BUFFER_SIZE, 1<<23, byte stride between buffers.
- ADDR_WIDTH, 32, address width; all address arithmetic is modulo 2^ADDR_WIDTH.
- clk  in  1  single clock for the whole block.
- reset  in  1  synchronous, active-high reset.
- base_address  in  ADDR_WIDTH  address of buffer 0; stable whenever reset is low.
- wr_finish  in  1  writer completed a frame; each high cycle is one event.
- rd_start  in  1  reader begins a frame; each high cycle is one event.
- wr_address  out  ADDR_WIDTH  start address for the writer's next or current frame.
- rd_address  out  ADDR_WIDTH  start address of the frame the reader is scanning.
- rd_valid  out  1  reader holds a real, completed frame.
- wr_idx  out  IDX_W  writer buffer index, for debug.
- rd_idx  out  IDX_W  reader buffer index, for debug.
- drop_count  out  16  frames completed but never displayed; saturating.
- repeat_count  out  16  reader frame starts with no new frame; saturating.

## Operation
- addr(i) = base_address + i*BUFFER_SIZE. IDX_W = clog2(NUM_BUFFERS).
- Internal state: wr_idx, rd_idx, latest_idx, latest_new (latest frame not yet consumed).
- Invariant: wr_idx != rd_idx at all times.
- Reset values: wr_idx=0, rd_idx=NUM_BUFFERS-1, latest_idx=0, latest_new=0, rd_valid=0, counters=0. Outputs: wr_address=base_address, rd_address=addr(NUM_BUFFERS-1).
- wr_finish only:
  - latest_idx<=wr_idx, latest_new<=1.
  - If latest_new was already 1, increment drop_count.
  - wr_idx<=n1 = (wr_idx+1) mod N. If n1==rd_idx, use (wr_idx+2) mod N instead.
- rd_start only:
  - If latest_new: rd_idx<=latest_idx, latest_new<=0, rd_valid<=1.
  - Otherwise rd_idx is unchanged and repeat_count increments. rd_valid stays as is.
- Both events in the same cycle:
  - Reader takes the just-finished buffer: rd_idx<=wr_idx, latest_idx<=wr_idx, latest_new<=0, rd_valid<=1.
  - wr_idx<=(wr_idx+1) mod N. The old rd_idx is released and may be selected.
  - If latest_new was 1, increment drop_count.
- latest_idx is never written while it equals the writer's target. Free-buffer selection only avoids rd_idx and the old wr_idx.
- reset while events are asserted: reset wins and all state returns to reset values.

## Timing
- All outputs are registered.
- wr_address, rd_address, wr_idx and rd_idx reflect an event on the cycle after it is sampled (latency 1).
- No backpressure: events are accepted every cycle, including back-to-back.
- The writer must sample wr_address on or after the cycle following wr_finish. The reader must sample rd_address on or after the cycle following rd_start.
- Counters update in the same cycle as the indices and hold at 0xFFFF.
- Multiplies by BUFFER_SIZE are constant. A power-of-two BUFFER_SIZE reduces to a shift. Address adders may be registered as part of the 1-cycle latency.

## Configuration
- FRAME_BUFFER_MANAGER_STATS_EN defined: drop_count and repeat_count are implemented as described.
- Macro undefined: counter registers are removed, both ports are tied to 0, and all other behaviour is identical.

## Structure
- Shared package fbm_pkg holds:
  - the STATS_W=16 constant;
  - the max NUM_BUFFERS constant (16);
  - the next-free-index function (wr_idx, rd_idx, N), used by RTL and the bench model.
- Single module, no sub-modules. The index-to-address computation stays inline.

## Test plan
All scenarios use N=3, BUFFER_SIZE=0x800000, base_address=0x10000000.
- Reset: wr_address=0x10000000, rd_address=0x11000000, rd_valid=0, counters=0.
- One wr_finish, then rd_start: wr_address=0x10800000; then rd_address=0x10000000, rd_valid=1, repeat_count=0.
- From the previous state, two wr_finish with no rd_start: wr_idx goes 1→2→1 (skips 0, which the reader holds); wr_address never 0x10000000; drop_count=1.
- wr_finish and rd_start in the same cycle with wr_idx=1, rd_idx=0: next cycle rd_address=0x10800000, wr_address=0x11000000.
- rd_start with latest_new=0: rd_address unchanged, repeat_count increments. Hold rd_start high for 70000 cycles: repeat_count saturates at 0xFFFF.
- reset asserted in the same cycle as wr_finish mid-stream: all outputs return to reset values. With the macro undefined, counters read 0 throughout.
